// File: rtl/l2_flatten_if.sv
// Control handshake and shared memory bus between the flatten engine and the feature-map memories.
// master = flatten engine, slave = memory / controller side.
interface l2_flatten_if;
    logic               start;
    logic               busy;
    logic               done;
    logic               crd;
    logic        [11:0] caddr_rd;
    logic signed [19:0] cdata_rd;
    logic               cwr;
    logic        [11:0] caddr_wr;
    logic signed [19:0] cdata_wr;
    logic        [2:0]  csel;

    modport master (
        input  start, cdata_rd,
        output busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );

    modport slave (
        output start, cdata_rd,
        input  busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
    );
endinterface

// File: rtl/l2_flatten.sv
// Interleaves two pooled layer-1 maps into one layer-2 map: L2[2i]=K0[i], L2[2i+1]=K1[i].
// Latency: 4 cycles per entry, 4*DEPTH busy cycles; no backpressure, start ignored while active.
module l2_flatten #(
    parameter int         DEPTH  = 1024,
    parameter logic [2:0] SEL_K0 = 3'b011,
    parameter logic [2:0] SEL_K1 = 3'b100,
    parameter logic [2:0] SEL_L2 = 3'b101
) (
    input  logic         clk,
    input  logic         reset,
    l2_flatten_if.master bus
);

    typedef enum logic [2:0] {IDLE, RD_K0, RD_K1, WR_EVEN, WR_ODD, DONE} state_t;

    localparam logic [11:0] LAST = 12'(DEPTH - 1);

    state_t             state, state_nxt;
    logic        [11:0] idx, idx_nxt;
    logic signed [19:0] d0, d1;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = RD_K0;
                    idx_nxt   = '0;
                end
            end
            RD_K0:   state_nxt = RD_K1;
            RD_K1:   state_nxt = WR_EVEN;
            WR_EVEN: state_nxt = WR_ODD;
            WR_ODD: begin
                if (idx == LAST) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = RD_K0;
                    idx_nxt   = idx + 12'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
            d0    <= '0;
            d1    <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (state == RD_K1)   d0 <= bus.cdata_rd;
            if (state == WR_EVEN) d1 <= bus.cdata_rd;
        end
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    // Write data loads the same returning read word that d0/d1 capture, so each write
    // goes out in the cycle right after its read data arrives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.crd      <= 1'b0;
            bus.cwr      <= 1'b0;
            bus.caddr_rd <= '0;
            bus.caddr_wr <= '0;
            bus.cdata_wr <= '0;
            bus.csel     <= '0;
        end else begin
            bus.busy <= (state_nxt == RD_K0) || (state_nxt == RD_K1) ||
                        (state_nxt == WR_EVEN) || (state_nxt == WR_ODD);
            bus.done <= (state_nxt == DONE);
            bus.crd  <= (state_nxt == RD_K0) || (state_nxt == RD_K1);
            bus.cwr  <= (state_nxt == WR_EVEN) || (state_nxt == WR_ODD);
            case (state_nxt)
                RD_K0: begin
                    bus.csel     <= SEL_K0;
                    bus.caddr_rd <= idx_nxt;
                end
                RD_K1: begin
                    bus.csel     <= SEL_K1;
                    bus.caddr_rd <= idx_nxt;
                end
                WR_EVEN: begin
                    bus.csel     <= SEL_L2;
                    bus.caddr_wr <= {idx_nxt[10:0], 1'b0};
                    bus.cdata_wr <= bus.cdata_rd;
                end
                WR_ODD: begin
                    bus.csel     <= SEL_L2;
                    bus.caddr_wr <= {idx_nxt[10:0], 1'b1};
                    bus.cdata_wr <= bus.cdata_rd;
                end
                default: bus.csel <= 3'b000;
            endcase
        end
    end

endmodule
